keypad_num_entry: RTL

Input side of the calculator datapath. It scans a 4x4 active-low matrix keypad and debounces each press. Each accepted key is reported as a one-cycle event with its code, and decimal digits are accumulated into a packed-BCD operand register. The operand register has the same 4-bit-per-digit packing that the display encoder consumes.

---
 rtl/keypad_num_entry.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_num_entry.sv
// rtl/keypad_num_entry.sv - 4x4 keypad scanner with debounce and packed-BCD operand entry
module keypad_num_entry #(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 4,
    parameter int DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            row,
    output logic [3:0]            col,
    input  logic                  clr,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   num_bcd,
    output logic [3:0]            num_cnt,
    output logic                  ovf
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int MW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE);

    typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_HOLD} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div;
    logic [1:0]    col_idx, col_idx_n;
    logic [1:0]    cand_row, cand_row_n;
    logic [MW-1:0] match, match_n, match_inc;
    logic          sample, any_low, accept;
    logic [1:0]    low_row;
    logic [3:0]    key_new;

    assign sample    = (div == DIV_LAST);
    assign any_low   = (row != 4'hF);
    assign match_inc = match + MW'(1);
    assign key_new   = {cand_row, col_idx};
    assign col       = ~(4'b0001 << col_idx);

    always_comb begin
        if (!row[0])      low_row = 2'd0;
        else if (!row[1]) low_row = 2'd1;
        else if (!row[2]) low_row = 2'd2;
        else              low_row = 2'd3;
    end

    // match counts agreeing press samples in ST_DEB and release samples in ST_HOLD
    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        cand_row_n = cand_row;
        match_n    = match;
        accept     = 1'b0;
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (!any_low) begin
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        cand_row_n = low_row;
                        match_n    = MW'(1);
                        state_n    = ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (any_low && low_row == cand_row) begin
                        if (match_inc == MATCH_MAX) begin
                            state_n = ST_HOLD;
                            match_n = '0;
                            accept  = 1'b1;
                        end else begin
                            match_n = match_inc;
                        end
                    end else begin
                        state_n   = ST_SCAN;
                        match_n   = '0;
                        col_idx_n = col_idx + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (any_low) begin
                        match_n = '0;
                    end else if (match_inc == MATCH_MAX) begin
                        state_n   = ST_SCAN;
                        match_n   = '0;
                        col_idx_n = col_idx + 2'd1;
                    end else begin
                        match_n = match_inc;
                    end
                end
                default: begin
                    state_n = ST_SCAN;
                    match_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SCAN;
            div      <= '0;
            col_idx  <= 2'd0;
            cand_row <= 2'd0;
            match    <= '0;
        end else begin
            state    <= state_n;
            div      <= sample ? '0 : div + DW'(1);
            col_idx  <= col_idx_n;
            cand_row <= cand_row_n;
            match    <= match_n;
        end
    end

    // Operand changes land together with the key_valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            num_bcd   <= '0;
            num_cnt   <= 4'd0;
            ovf       <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= key_new;
            if (clr) begin
                num_bcd <= '0;
                num_cnt <= 4'd0;
                ovf     <= 1'b0;
            end else if (accept) begin
                if (key_new < 4'd10) begin
                    if (num_cnt == 4'd0 && key_new == 4'd0) begin
                        num_cnt <= num_cnt;
                    end else if (num_cnt == 4'(DIGITS)) begin
                        ovf <= 1'b1;
                    end else begin
                        num_bcd <= {num_bcd[4*DIGITS-5:0], key_new};
                        num_cnt <= num_cnt + 4'd1;
                    end
                end else if (key_new == 4'd14) begin
                    num_bcd <= '0;
                    num_cnt <= 4'd0;
                    ovf     <= 1'b0;
                end
            end
        end
    end

endmodule
